// File: rtl/mem_trans_ctrl_pkg.sv
// Shared definitions for the memTrans access sequencer.
//   - Default parameter values (address MSB, data width, access length).
//   - Access timer width.
//   - FSM state encoding used by mem_trans_ctrl.
package mem_trans_ctrl_pkg;

  localparam int unsigned NdirDefault   = 7;
  localparam int unsigned DwDefault     = 32;
  localparam int unsigned AccCycDefault = 2;

  // Wide enough for ACC_CYC up to 15.
  localparam int unsigned TimerW = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWrite = 3'd1,
    StTurn  = 3'd2,
    StRead  = 3'd3,
    StResp  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_trans_ctrl_acc_timer.sv
// Access-length down-counter.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   load     : load load_val this cycle
//   load_val : start value (number of remaining cycles minus one)
//   done     : count has reached zero (last cycle of the access)
module mem_trans_ctrl_acc_timer
  import mem_trans_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TimerW-1:0] load_val,
  output logic              done
);

  logic [TimerW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_trans_ctrl.sv
// Upstream access sequencer for the transparent memory model (memTrans).
// Accepts one read/write request at a time, drives dir/LE/dato with a
// turnaround cycle after every write, returns read data over a valid/ready
// channel and counts completed transactions.
//   CLK, iCLR            : clock (rising edge), async active-low reset
//   req_valid/req_ready  : request handshake; req_we, req_dir, req_wdata fields
//   rsp_valid/rsp_ready  : read response handshake; rsp_rdata payload
//   wr_done              : one-cycle pulse when a write completes
//   busy                 : controller not idle
//   txn_cnt              : completed transactions (wrapping)
//   dir, LE, dato        : memory address, write enable, shared data bus
module mem_trans_ctrl
  import mem_trans_ctrl_pkg::*;
#(
  parameter int unsigned NDIR    = NdirDefault,
  parameter int unsigned DW      = DwDefault,
  parameter int unsigned ACC_CYC = AccCycDefault
) (
  input  logic          CLK,
  input  logic          iCLR,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [NDIR:0] req_dir,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          wr_done,
  output logic          busy,
  output logic [15:0]   txn_cnt,
  output logic [NDIR:0] dir,
  output logic          LE,
  inout  wire  [DW-1:0] dato
);

  localparam logic [TimerW-1:0] LoadVal = TimerW'(ACC_CYC - 1);

  state_e state_q, state_d;

  logic [NDIR:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [15:0]   txn_cnt_q, txn_cnt_d;

  logic accept;
  logic tmr_done;

  assign accept = req_valid && req_ready;

  mem_trans_ctrl_acc_timer u_acc_timer (
    .clk      (CLK),
    .rst_n    (iCLR),
    .load     (accept),
    .load_val (LoadVal),
    .done     (tmr_done)
  );

  // State register
  always_ff @(posedge CLK or negedge iCLR) begin
    if (!iCLR) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = req_we ? StWrite : StRead;
      StWrite: if (tmr_done) state_d = StTurn;
      StTurn:  state_d = StIdle;
      StRead:  if (tmr_done) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = 1'b0;
    LE        = 1'b0;
    wr_done   = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        // Held low while reset is asserted even though the state is already idle.
        req_ready = iCLR;
        busy      = 1'b0;
      end
      StWrite: LE = 1'b1;
      StTurn:  wr_done = 1'b1;
      StRead:  ;
      StResp:  rsp_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath registers: request capture, read sample, transaction count
  always_ff @(posedge CLK or negedge iCLR) begin
    if (!iCLR) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      txn_cnt_q <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    txn_cnt_d = txn_cnt_q;
    if (accept) begin
      addr_d  = req_dir;
      wdata_d = req_wdata;
    end
    // Sample on the last read cycle; bus value is taken as-is.
    if ((state_q == StRead) && tmr_done) begin
      rdata_d = dato;
    end
    if ((state_q == StTurn) || ((state_q == StResp) && rsp_ready)) begin
      txn_cnt_d = txn_cnt_q + 16'd1;
    end
  end

  assign dir       = addr_q;
  assign rsp_rdata = rdata_q;
  assign txn_cnt   = txn_cnt_q;

  // Controller owns the bus only while LE is high; the memory drives it otherwise.
  assign dato = LE ? wdata_q : {DW{1'bz}};

endmodule
